// File: rtl/winograd_tile_feeder.sv
// winograd_tile_feeder: builds stride-2 4-sample tiles and holds F(2,3) taps.
// Define WTF_ZERO_PAD_EN for "same" padding (one zero at each row end).
module winograd_tile_feeder #(
  parameter int DATA_W  = 32,
  parameter int ROW_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in1,
  input  logic [DATA_W-1:0] w_in2,
  input  logic [DATA_W-1:0] w_in3,
  output logic              w_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] r1_x,
  output logic [DATA_W-1:0] r2_x,
  output logic [DATA_W-1:0] r3_x,
  output logic [DATA_W-1:0] r4_x,
  output logic [DATA_W-1:0] r1_w,
  output logic [DATA_W-1:0] r2_w,
  output logic [DATA_W-1:0] r3_w
);

  typedef enum logic [1:0] {
    FILL,
    OUT,
    STEP
  } state_t;

`ifdef WTF_ZERO_PAD_EN
  localparam int NT = ROW_LEN / 2;
  localparam logic [1:0] FILL_END = 2'd2;
`else
  localparam int NT = (ROW_LEN - 2) / 2;
  localparam logic [1:0] FILL_END = 2'd3;
`endif
  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [TW-1:0] LAST = TW'(NT - 1);

  state_t state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [3:0][DATA_W-1:0] win_q, win_d;
  logic accept;
  logic last_tile;
  logic inject;
  logic w_ok;

  assign last_tile = tile_q == LAST;
  assign out_valid = state_q == OUT;
  assign out_last  = out_valid && last_tile;

`ifdef WTF_ZERO_PAD_EN
  assign inject = state_q == STEP
               && last_tile
               && col_q == 2'd1;
`else
  assign inject = 1'b0;
`endif

  assign in_ready = rst_n && !out_valid && !inject;
  assign accept   = in_valid && in_ready;
  assign w_ok     = state_q == FILL && col_q == 2'd0;

  assign r1_x = win_q[0];
  assign r2_x = win_q[1];
  assign r3_x = win_q[2];
  assign r4_x = win_q[3];

  // Registers for FSM state, counters and the sample window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      tile_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      win_q   <= win_d;
    end
  end

  // Next state: count samples per phase, shift window, advance tiles
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tile_d  = tile_q;
    win_d   = win_q;
    if (accept) begin
      win_d = {in_data, win_q[3:1]};
    end
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (col_q == FILL_END) begin
            state_d = OUT;
            col_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_tile) begin
            state_d = FILL;
            col_d   = '0;
            tile_d  = '0;
            win_d   = '0;
          end else begin
            state_d = STEP;
            tile_d  = tile_q + TW'(1);
          end
        end
      end
      STEP: begin
        if (inject) begin
          win_d   = {{DATA_W{1'b0}}, win_q[3:1]};
          state_d = OUT;
          col_d   = '0;
        end else if (accept) begin
          if (col_q == 2'd1) begin
            state_d = OUT;
            col_d   = '0;
          end else begin
            col_d = 2'd1;
          end
        end
      end
      default: begin
        state_d = FILL;
        col_d   = '0;
        tile_d  = '0;
        win_d   = '0;
      end
    endcase
  end

  // Filter taps load only while the row is idle; else flag an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_w  <= '0;
      r2_w  <= '0;
      r3_w  <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_load && !w_ok;
      if (w_load && w_ok) begin
        r1_w <= w_in1;
        r2_w <= w_in2;
        r3_w <= w_in3;
      end
    end
  end

endmodule
